// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage data-memory access controller.
// Sits between the EX/MEM register and the data memory. It turns
// a load/store into a single word-wide REQ/ACK transaction with
// byte enables, stalls the pipeline for the whole transaction and
// returns extended load data for the MEM/WB register.
//
// Build option: define MISALIGN_TRAP_EN to trap misaligned H/HU/W
// accesses. A trapped access issues no memory request and raises
// MISALIGN for one cycle. Without the macro, the low address bits
// are ignored for alignment and MISALIGN stays 0.
module mem_access_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  MEM_READ,
    input  logic                  MEM_WRITE,
    input  logic [2:0]            FUNCT3,
    input  logic [ADDR_WIDTH-1:0] ALU_RESULT,
    input  logic [DATA_WIDTH-1:0] STORE_DATA,
    output logic                  BUSY_WAIT,
    output logic [DATA_WIDTH-1:0] DATA_READED,
    output logic                  MISALIGN,
    output logic                  DMEM_REQ,
    output logic                  DMEM_WE,
    output logic [ADDR_WIDTH-3:0] DMEM_ADDR,
    output logic [DATA_WIDTH-1:0] DMEM_WDATA,
    output logic [3:0]            DMEM_BE,
    input  logic                  DMEM_ACK,
    input  logic [DATA_WIDTH-1:0] DMEM_RDATA
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    // Access size from FUNCT3; the unsupported codes 011/110/111 fall to word.
    function automatic size_t decode_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    // Byte offset actually used: halfwords only look at a[1], words at none.
    function automatic logic [1:0] lane_offset(input size_t sz, input logic [1:0] a);
        case (sz)
            SZ_B:    return a;
            SZ_H:    return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    // Byte enables for the selected lane(s).
    function automatic logic [3:0] store_be(input size_t sz, input logic [1:0] off);
        case (sz)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data replicated across all lanes so the memory can pick any lane.
    function automatic logic [31:0] store_wdata(input size_t sz, input logic [31:0] d);
        case (sz)
            SZ_B:    return {4{d[7:0]}};
            SZ_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Extract the addressed byte/halfword and sign- or zero-extend it.
    function automatic logic [31:0] load_extend(input size_t sz, input logic uns,
                                                input logic [1:0] off,
                                                input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (sz)
            SZ_B:    return uns ? {24'h000000, b} : {{24{b[7]}}, b};
            SZ_H:    return uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: return rdata;
        endcase
    endfunction

`ifdef MISALIGN_TRAP_EN
    // Halfwords need a[0]=0, words need a=00; bytes are always aligned.
    function automatic logic is_misaligned(input size_t sz, input logic [1:0] a);
        case (sz)
            SZ_B:    return 1'b0;
            SZ_H:    return a[0];
            default: return a != 2'b00;
        endcase
    endfunction
`endif

    state_t     state;
    size_t      ld_size;
    logic       ld_uns;
    logic       ld_read;
    logic [1:0] ld_off;

    logic       req_any;
    size_t      req_size;
    logic [1:0] req_off;
    logic       trap;

    assign req_any  = MEM_READ | MEM_WRITE;
    assign req_size = decode_size(FUNCT3);
    assign req_off  = lane_offset(req_size, ALU_RESULT[1:0]);

`ifdef MISALIGN_TRAP_EN
    assign trap = is_misaligned(req_size, ALU_RESULT[1:0]);
`else
    assign trap = 1'b0;
`endif

    // Stall while a request is being detected or is outstanding; DONE lets the pipeline move.
    always_comb begin
        BUSY_WAIT = ~RESET & (((state == IDLE) & req_any) | (state == ACCESS));
    end

    // Transaction FSM with registered memory-side outputs and load result.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            DMEM_REQ    <= 1'b0;
            DMEM_WE     <= 1'b0;
            DMEM_ADDR   <= '0;
            DMEM_WDATA  <= '0;
            DMEM_BE     <= 4'b0000;
            DATA_READED <= '0;
            MISALIGN    <= 1'b0;
            ld_size     <= SZ_W;
            ld_uns      <= 1'b0;
            ld_read     <= 1'b0;
            ld_off      <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    MISALIGN <= 1'b0;
                    if (req_any) begin
                        // Remember how to extract the load once the word comes back.
                        ld_size <= req_size;
                        ld_uns  <= FUNCT3[2];
                        ld_off  <= req_off;
                        ld_read <= ~MEM_WRITE;
                        if (trap) begin
                            MISALIGN <= 1'b1;
                            state    <= DONE;
                        end else begin
                            DMEM_REQ   <= 1'b1;
                            DMEM_WE    <= MEM_WRITE;
                            DMEM_ADDR  <= ALU_RESULT[ADDR_WIDTH-1:2];
                            DMEM_WDATA <= store_wdata(req_size, STORE_DATA);
                            DMEM_BE    <= store_be(req_size, req_off);
                            state      <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (DMEM_ACK) begin
                        DMEM_REQ <= 1'b0;
                        if (ld_read) begin
                            DATA_READED <= load_extend(ld_size, ld_uns, ld_off, DMEM_RDATA);
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    // The same instruction is still presented here; returning
                    // to IDLE only after this cycle keeps it from re-issuing.
                    MISALIGN <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed loads/stores with a bench-side
// model of lane selection and extension, a per-cycle compare process and
// literal expectations for the headline cases.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [2:0]  FUNCT3;
    logic [31:0] ALU_RESULT;
    logic [31:0] STORE_DATA;
    logic        BUSY_WAIT;
    logic [31:0] DATA_READED;
    logic        MISALIGN;
    logic        DMEM_REQ;
    logic        DMEM_WE;
    logic [29:0] DMEM_ADDR;
    logic [31:0] DMEM_WDATA;
    logic [3:0]  DMEM_BE;
    logic        DMEM_ACK;
    logic [31:0] DMEM_RDATA;

    mem_access_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .FUNCT3(FUNCT3), .ALU_RESULT(ALU_RESULT), .STORE_DATA(STORE_DATA),
        .BUSY_WAIT(BUSY_WAIT), .DATA_READED(DATA_READED), .MISALIGN(MISALIGN),
        .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
        .DMEM_WDATA(DMEM_WDATA), .DMEM_BE(DMEM_BE), .DMEM_ACK(DMEM_ACK),
        .DMEM_RDATA(DMEM_RDATA)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Model state: what the DUT must show
    logic [31:0] exp_rd;
    logic        exp_mis;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;

    // Values observed during the last transaction
    int          busy_cnt;
    int          req_rises;
    logic [31:0] cap_addr;
    logic        cap_we;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // ---- behavioural model ----
    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // Lowest byte touched: the address rounded down to the access size.
    function automatic int lane(input logic [2:0] f3, input logic [31:0] addr);
        int a;
        a = int'(addr[1:0]);
        return a - (a % nbytes(f3));
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
        int v;
        v = ((1 << nbytes(f3)) - 1) << lane(f3, addr);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] r;
        int n;
        n = nbytes(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        longint v;
        int n;
        n = nbytes(f3);
        v = longint'(rdata >> (8 * lane(f3, addr)));
        v = v & ((longint'(1) << (8 * n)) - 1);
        if (n < 4 && !f3[2] && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    function automatic bit m_trap(input logic [2:0] f3, input logic [31:0] addr);
`ifdef MISALIGN_TRAP_EN
        return (nbytes(f3) > 1) && ((int'(addr[1:0]) % nbytes(f3)) != 0);
`else
        return (f3 == 3'b111) && (addr == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    // Per-cycle comparison against the model
    always @(negedge CLK) begin
        if (cmp_en) begin
            check("cyc DATA_READED", DATA_READED, exp_rd);
            check("cyc MISALIGN", {31'b0, MISALIGN}, {31'b0, exp_mis});
            if (DMEM_REQ) begin
                check("cyc DMEM_ADDR", {2'b00, DMEM_ADDR}, exp_addr);
                check("cyc DMEM_WE", {31'b0, DMEM_WE}, {31'b0, exp_we});
                check("cyc DMEM_BE", {28'b0, DMEM_BE}, {28'b0, exp_be});
                if (exp_we) check("cyc DMEM_WDATA", DMEM_WDATA, exp_wdata);
            end
        end
    end

    // Present one instruction, answer its request after d cycles, return in DONE.
    task automatic do_access(input string name, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] sd, input int d, input logic [31:0] rdata);
        bit trap, done, ack_drv, prev_req;
        int k;
        trap = m_trap(f3, addr);
        @(posedge CLK); #1;
        exp_mis    = 1'b0;
        MEM_READ   = rd;
        MEM_WRITE  = wr;
        FUNCT3     = f3;
        ALU_RESULT = addr;
        STORE_DATA = sd;
        exp_addr   = {2'b00, addr[31:2]};
        exp_we     = wr;
        exp_be     = m_be(f3, addr);
        exp_wdata  = m_wdata(f3, sd);
        busy_cnt = 0; req_rises = 0; k = 0; done = 0; ack_drv = 0; prev_req = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge CLK);
            if (c == 0) check({name, " busy on issue"}, {31'b0, BUSY_WAIT}, 32'd1);
            if (BUSY_WAIT) busy_cnt++;
            if (DMEM_REQ) begin
                if (!prev_req) begin
                    req_rises++;
                    cap_addr  = {2'b00, DMEM_ADDR};
                    cap_we    = DMEM_WE;
                    cap_wdata = DMEM_WDATA;
                    cap_be    = DMEM_BE;
                end
                k++;
                if (k == d) begin
                    DMEM_ACK   = 1'b1;
                    DMEM_RDATA = rdata;
                    ack_drv    = 1'b1;
                end else begin
                    DMEM_ACK = 1'b0;
                end
            end else begin
                DMEM_ACK = 1'b0;
                if (c > 0 && !BUSY_WAIT) done = 1'b1;
            end
            prev_req = DMEM_REQ;
            if (!done) begin
                @(posedge CLK); #1;
                if (ack_drv) begin
                    ack_drv = 1'b0;
                    if (rd && !wr) exp_rd = m_load(f3, addr, rdata);
                end
                if (c == 0 && trap) exp_mis = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: no DONE within 40 cycles, required completion", name);
        end else begin
            check({name, " busy cycles"}, busy_cnt, trap ? 32'd1 : 32'(1 + d));
            check({name, " req count"}, req_rises, trap ? 32'd0 : 32'd1);
            check({name, " misalign in DONE"}, {31'b0, MISALIGN}, {31'b0, trap});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            exp_mis   = 1'b0;
            MEM_READ  = 1'b0;
            MEM_WRITE = 1'b0;
            @(negedge CLK);
            check("idle busy", {31'b0, BUSY_WAIT}, 32'd0);
            check("idle req", {31'b0, DMEM_REQ}, 32'd0);
        end
    endtask

    initial begin
        RESET = 1'b1; MEM_READ = 1'b1; MEM_WRITE = 1'b0; FUNCT3 = 3'b010;
        ALU_RESULT = 32'h0; STORE_DATA = 32'h0; DMEM_ACK = 1'b0; DMEM_RDATA = 32'h0;
        exp_rd = 32'h0; exp_mis = 1'b0; exp_addr = 32'h0; exp_we = 1'b0;
        exp_wdata = 32'h0; exp_be = 4'h0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset busy forced", {31'b0, BUSY_WAIT}, 32'd0);
        check("reset req", {31'b0, DMEM_REQ}, 32'd0);
        check("reset we", {31'b0, DMEM_WE}, 32'd0);
        check("reset addr", {2'b00, DMEM_ADDR}, 32'd0);
        check("reset wdata", DMEM_WDATA, 32'd0);
        check("reset be", {28'b0, DMEM_BE}, 32'd0);
        check("reset data", DATA_READED, 32'd0);
        check("reset misalign", {31'b0, MISALIGN}, 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b0; MEM_READ = 1'b0;
        cmp_en = 1'b1;

        do_access("lw", 1, 0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF);
        check("lw addr", cap_addr, 32'h40);
        check("lw be", {28'b0, cap_be}, 32'hF);
        check("lw busy3", busy_cnt, 32'd3);
        check("lw data", DATA_READED, 32'hDEADBEEF);

        do_access("lb", 1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80112233);
        check("lb data", DATA_READED, 32'hFFFFFF80);
        do_access("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80112233);
        check("lbu data", DATA_READED, 32'h00000080);
        do_access("lhu", 1, 0, 3'b101, 32'h102, 32'h0, 1, 32'h80112233);
        check("lhu data", DATA_READED, 32'h00008011);
        do_access("lh", 1, 0, 3'b001, 32'h102, 32'h0, 2, 32'h80112233);
        check("lh data", DATA_READED, 32'hFFFF8011);
        do_access("l011", 1, 0, 3'b011, 32'h104, 32'h0, 3, 32'hCAFEF00D);
        check("l011 data", DATA_READED, 32'hCAFEF00D);

        do_access("sb", 0, 1, 3'b000, 32'h201, 32'h000000A5, 1, 32'h0);
        check("sb we", {31'b0, cap_we}, 32'd1);
        check("sb wdata", cap_wdata, 32'hA5A5A5A5);
        check("sb be", {28'b0, cap_be}, 32'h2);
        check("sb keeps data", DATA_READED, 32'hCAFEF00D);
        do_access("sh", 0, 1, 3'b001, 32'h202, 32'h00001234, 2, 32'h0);
        check("sh wdata", cap_wdata, 32'h12341234);
        check("sh be", {28'b0, cap_be}, 32'hC);
        do_access("rw", 1, 1, 3'b010, 32'h208, 32'h0BADF00D, 1, 32'h77777777);
        check("rw as write", {31'b0, cap_we}, 32'd1);
        check("rw keeps data", DATA_READED, 32'hCAFEF00D);
        idle(2);

        // Back-to-back: the second issue is checked busy on its first cycle
        do_access("b2b lw", 1, 0, 3'b010, 32'h300, 32'h0, 1, 32'h01234567);
        check("b2b lw data", DATA_READED, 32'h01234567);
        do_access("b2b sw", 0, 1, 3'b010, 32'h304, 32'h89ABCDEF, 1, 32'h0);
        check("b2b sw wdata", cap_wdata, 32'h89ABCDEF);
        check("b2b sw be", {28'b0, cap_be}, 32'hF);
        idle(3);

        do_access("lw mis", 1, 0, 3'b010, 32'h102, 32'h0, 1, 32'h55667788);
`ifdef MISALIGN_TRAP_EN
        check("lw mis no req", req_rises, 32'd0);
        check("lw mis flag", {31'b0, MISALIGN}, 32'd1);
        check("lw mis data kept", DATA_READED, 32'h01234567);
`else
        check("lw mis addr", cap_addr, 32'h40);
        check("lw mis be", {28'b0, cap_be}, 32'hF);
        check("lw mis flag", {31'b0, MISALIGN}, 32'd0);
        check("lw mis data", DATA_READED, 32'h55667788);
`endif
        idle(2);
        check("misalign one cycle", {31'b0, MISALIGN}, 32'd0);

        // Reset while the access is outstanding; the late ACK must be ignored
        @(posedge CLK); #1;
        MEM_READ = 1'b1; MEM_WRITE = 1'b0; FUNCT3 = 3'b010; ALU_RESULT = 32'h400;
        exp_addr = 32'h100; exp_we = 1'b0; exp_be = 4'hF;
        @(negedge CLK);
        check("abort busy idle", {31'b0, BUSY_WAIT}, 32'd1);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(negedge CLK);
        check("abort busy forced", {31'b0, BUSY_WAIT}, 32'd0);
        check("abort req before edge", {31'b0, DMEM_REQ}, 32'd1);
        @(posedge CLK); #1;
        RESET = 1'b0; MEM_READ = 1'b0;
        DMEM_ACK = 1'b1; DMEM_RDATA = 32'h12345678;
        exp_rd = 32'h0;
        @(negedge CLK);
        check("abort req", {31'b0, DMEM_REQ}, 32'd0);
        check("abort busy", {31'b0, BUSY_WAIT}, 32'd0);
        check("abort data", DATA_READED, 32'd0);
        @(posedge CLK); #1;
        DMEM_ACK = 1'b0;
        @(negedge CLK);
        check("late ack ignored", DATA_READED, 32'd0);
        check("late ack req", {31'b0, DMEM_REQ}, 32'd0);

        do_access("post lbu", 1, 0, 3'b100, 32'h401, 32'h0, 1, 32'h0000AB00);
        check("post lbu data", DATA_READED, 32'h000000AB);
        idle(2);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
